// File: rtl/he_pkg.sv
// Shared types for the homomorphic-op sequencer: opcodes, sequencer states
// and the per-opcode row count.
package he_pkg;

  typedef enum logic [1:0] {
    OP_ENCRYPT = 2'd0,
    OP_DECRYPT = 2'd1,
    OP_ADD     = 2'd2,
    OP_MULT    = 2'd3
  } he_opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Encrypt walks the public-key rows; every other op walks the n+1 rows of a ciphertext.
  function automatic int row_count(logic [1:0] opcode, int dimension, int big_n);
    if (opcode == OP_ENCRYPT) return big_n;
    return dimension + 1;
  endfunction

endpackage

// File: rtl/he_cmd_fifo.sv
// Synchronous command FIFO with registered count; a push is dropped when full,
// even if a pop happens in the same cycle.
module he_cmd_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/he_op_sequencer.sv
// Command-queued HE op sequencer: walks each command's rows LANES per beat
// toward the engines. Define HE_SEQ_PERF_EN to build the busy/stall counters.
module he_op_sequencer
  import he_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DIMENSION  = 10,
  parameter int BIG_N      = 30,
  parameter int LANES      = 1,
  parameter int CMD_DEPTH  = 4,
  localparam int ROW_WIDTH =
    $clog2(((BIG_N > DIMENSION + 1) ? BIG_N : DIMENSION + 1) + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_op1_base,
  input  logic [ADDR_WIDTH-1:0] cmd_op2_base,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [1:0]            issue_opcode,
  output logic [ROW_WIDTH-1:0]  issue_row,
  output logic [ADDR_WIDTH-1:0] issue_op1_addr,
  output logic [ADDR_WIDTH-1:0] issue_op2_addr,
  output logic [LANES-1:0]      issue_lane_mask,
  output logic                  issue_first,
  output logic                  issue_last,
  input  logic                  dp_done,
  output logic                  op_done,
  output logic [1:0]            done_opcode,
  output logic                  busy,
  output logic                  protocol_err,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles,
  output logic [1:0]            dbg_state
);

  localparam int CMD_W = 2 + 2 * ADDR_WIDTH;

  // Handshakes: a command is taken when cmd_valid && cmd_ready; a beat moves when
  // issue_valid && issue_ready, and the beat is held unchanged until then.
  seq_state_t              r_state;
  seq_state_t              w_next;
  logic [1:0]              r_opcode;
  logic [ADDR_WIDTH-1:0]   r_op1_base;
  logic [ADDR_WIDTH-1:0]   r_op2_base;
  logic [ROW_WIDTH-1:0]    r_row;
  logic [ROW_WIDTH-1:0]    r_rows;
  logic                    r_err;

  logic [CMD_W-1:0]        w_head;
  logic [1:0]              w_h_op;
  logic [ADDR_WIDTH-1:0]   w_h_op1;
  logic [ADDR_WIDTH-1:0]   w_h_op2;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(CMD_DEPTH):0] w_count;
  logic                    w_pop;
  logic                    w_advance;
  logic                    w_issue;
  logic                    w_last;
  logic                    w_busy;
  logic [LANES-1:0]        w_mask;

  he_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_data  ({cmd_opcode, cmd_op1_base, cmd_op2_base}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign {w_h_op, w_h_op1, w_h_op2} = w_head;

  assign w_issue = (r_state == ST_ISSUE);
  assign w_last  = (32'(r_row) + 32'(LANES) >= 32'(r_rows));
  assign w_busy  = (r_state != ST_IDLE) || (w_count != '0);

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_next = ST_ISSUE;
                end
      ST_ISSUE: if (issue_ready) begin
                  if (w_last) w_next    = ST_WAIT;
                  else        w_advance = 1'b1;
                end
      ST_WAIT:  if (dp_done) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode   <= '0;
      r_op1_base <= '0;
      r_op2_base <= '0;
      r_row      <= '0;
      r_rows     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_opcode   <= w_h_op;
        r_op1_base <= w_h_op1;
        r_op2_base <= w_h_op2;
        r_row      <= '0;
        r_rows     <= ROW_WIDTH'(row_count(w_h_op, DIMENSION, BIG_N));
      end else if (w_advance) begin
        r_row <= ROW_WIDTH'(32'(r_row) + 32'(LANES));
      end
      // A completion outside WAIT has no command to retire; flag it until reset.
      if (dp_done && r_state != ST_WAIT) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < LANES; k++)
      w_mask[k] = w_issue && (32'(r_row) + 32'(k) < 32'(r_rows));
  end

  assign cmd_ready       = !w_full;
  assign issue_valid     = w_issue;
  assign issue_opcode    = r_opcode;
  assign issue_row       = r_row;
  assign issue_op1_addr  = r_op1_base + ADDR_WIDTH'(r_row);
  assign issue_op2_addr  = r_op2_base + ADDR_WIDTH'(r_row);
  assign issue_lane_mask = w_mask;
  assign issue_first     = w_issue && (r_row == '0);
  assign issue_last      = w_issue && w_last;
  assign op_done         = (r_state == ST_DONE);
  assign done_opcode     = op_done ? r_opcode : 2'b00;
  assign busy            = w_busy;
  assign protocol_err    = r_err;
  assign dbg_state       = r_state;

`ifdef HE_SEQ_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_busy && r_perf_busy != '1) r_perf_busy <= r_perf_busy + 1'b1;
      if (w_issue && !issue_ready && r_perf_stall != '1)
        r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_busy_cycles  = r_perf_busy;
  assign perf_stall_cycles = r_perf_stall;
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule
